// File: rtl/vmem_fill.sv
// vmem_fill: rectangle-fill writer for the 640x480x24 frame memory.
// Takes one fill command at a time over a valid/ready handshake, clips it
// to the visible area and emits one pixel write per clock in raster order.
// Write addresses are packed {x[9:0], y[8:0]}, matching the scan-out side.
// Optional build macro VMEM_FILL_PERF_EN adds saturating pix_count and
// stall_count outputs; without it those ports and counters do not exist.
module vmem_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [23:0] cmd_color,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  input  logic        wr_stall,
  output logic        busy,
  output logic        done
`ifdef VMEM_FILL_PERF_EN
  ,
  output logic [19:0] pix_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Exclusive end coordinate of a span, clipped to the visible limit.
  // Operands are 11 bits wide so 1023 + 1023 cannot overflow.
  function automatic logic [10:0] clip_end(input logic [10:0] start,
                                           input logic [10:0] len,
                                           input logic [10:0] lim);
    logic [10:0] sum;
    sum = start + len;
    return (sum > lim) ? lim : sum;
  endfunction

  state_t      r_state;
  logic [9:0]  r_x0;
  logic [9:0]  r_x_last;
  logic [8:0]  r_y_last;

  logic        w_hs;
  logic        w_empty;
  logic [9:0]  w_x_last;
  logic [8:0]  w_y_last;
  logic        w_accept;
  logic [9:0]  w_cur_x;
  logic [8:0]  w_cur_y;
  logic        w_row_end;
  logic        w_last;
  logic [9:0]  w_x_next;
  logic [8:0]  w_y_next;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_hs      = cmd_valid & cmd_ready;

  // An empty rectangle produces no writes at all, only the done pulse.
  assign w_empty = (cmd_w == 10'd0) | (cmd_h == 9'd0) |
                   ({1'b0, cmd_x} >= 11'(H_RES)) |
                   ({2'b00, cmd_y} >= 11'(V_RES));

  // Last column/row actually written; only meaningful for non-empty commands.
  assign w_x_last = 10'(clip_end({1'b0, cmd_x}, {1'b0, cmd_w}, 11'(H_RES)) - 11'd1);
  assign w_y_last = 9'(clip_end({2'b00, cmd_y}, {2'b00, cmd_h}, 11'(V_RES)) - 11'd1);

  // The current pixel position lives in wr_addr itself, so it naturally
  // holds while the memory stalls.
  assign w_cur_x   = wr_addr[18:9];
  assign w_cur_y   = wr_addr[8:0];
  assign w_accept  = wr_en & ~wr_stall;
  assign w_row_end = (w_cur_x == r_x_last);
  assign w_last    = w_row_end & (w_cur_y == r_y_last);
  assign w_x_next  = w_row_end ? r_x0 : (w_cur_x + 10'd1);
  assign w_y_next  = w_row_end ? (w_cur_y + 9'd1) : w_cur_y;

  // Control FSM with registered write port, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (w_hs) begin
            busy <= 1'b1;
            if (w_empty) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state  <= S_FILL;
              wr_en    <= 1'b1;
              wr_addr  <= {cmd_x, cmd_y};
              wr_data  <= cmd_color;
              r_x0     <= cmd_x;
              r_x_last <= w_x_last;
              r_y_last <= w_y_last;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              wr_en   <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              wr_addr <= {w_x_next, w_y_next};
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          wr_en   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef VMEM_FILL_PERF_EN
  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : (v + 20'd1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Saturating counters of accepted writes and stalled write cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count   <= '0;
      stall_count <= '0;
    end else begin
      if (wr_en & ~wr_stall) pix_count   <= sat_inc20(pix_count);
      if (wr_en &  wr_stall) stall_count <= sat_inc16(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_vmem_fill.sv
// tb_vmem_fill: self-checking bench for vmem_fill. A queue-of-pixels model
// predicts every output each cycle; directed scenarios pin exact cycles and
// addresses with literal expectations; a random phase mixes commands, stalls
// and resets.
module tb_vmem_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_stall;
  logic        busy;
  logic        done;
`ifdef VMEM_FILL_PERF_EN
  logic [19:0] pix_count;
  logic [15:0] stall_count;
`endif

  always #5 clk = ~clk;

  vmem_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_stall(wr_stall), .busy(busy), .done(done)
`ifdef VMEM_FILL_PERF_EN
    , .pix_count(pix_count), .stall_count(stall_count)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Event logs filled from observed DUT behaviour.
  int          hs_log[$];
  int          wr_cyc[$];
  logic [42:0] wr_log[$];
  logic [18:0] stl_log[$];
  int          done_log[$];
  int          rdy_log[$];

  // Reference model: pending pixels of the current command, plus done flag.
  logic [42:0] mq[$];
  bit          m_done = 0;
  int          m_pix = 0;
  int          m_stall = 0;
  bit          run_cmp = 0;

  // Stall control.
  bit stall_rand = 0;
  int stall_lo = 1 << 30;
  int stall_hi = -1;

  always @(posedge clk) begin
    #1;
    if (stall_rand) wr_stall = ($urandom_range(0, 3) == 0);
    else            wr_stall = (cyc >= stall_lo) && (cyc <= stall_hi);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Per-cycle compare and model update.
  initial begin
    bit first = 1;
    bit prev_ready = 0;
    bit e_en;
    int xe, ye;
    wait (run_cmp);
    forever begin
      @(negedge clk);
      e_en = (mq.size() > 0);
      chk("wr_en", wr_en, e_en);
      chk("done", done, m_done);
      chk("busy", busy, e_en || m_done);
      chk("cmd_ready", cmd_ready, !(e_en || m_done));
      if (e_en) begin
        chk("wr_addr", wr_addr, mq[0][42:24]);
        chk("wr_data", wr_data, mq[0][23:0]);
      end
`ifdef VMEM_FILL_PERF_EN
      chk("pix_count", pix_count, m_pix);
      chk("stall_count", stall_count, m_stall);
`endif
      if (cmd_valid && cmd_ready) hs_log.push_back(cyc);
      if (wr_en && !wr_stall) begin
        wr_cyc.push_back(cyc);
        wr_log.push_back({wr_addr, wr_data});
      end
      if (wr_en && wr_stall) stl_log.push_back(wr_addr);
      if (done) done_log.push_back(cyc);
      if (!first && cmd_ready && !prev_ready) rdy_log.push_back(cyc);
      prev_ready = cmd_ready;
      first = 0;

      if (rst) begin
        mq.delete();
        m_done = 0;
        m_pix = 0;
        m_stall = 0;
      end else begin
        if (e_en && !wr_stall) m_pix = (m_pix == 20'hFFFFF) ? m_pix : m_pix + 1;
        if (e_en && wr_stall)  m_stall = (m_stall == 16'hFFFF) ? m_stall : m_stall + 1;
        if (m_done) begin
          m_done = 0;
        end else if (e_en) begin
          if (!wr_stall) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_done = 1;
          end
        end else if (cmd_valid) begin
          xe = int'(cmd_x) + int'(cmd_w);
          if (xe > 640) xe = 640;
          ye = int'(cmd_y) + int'(cmd_h);
          if (ye > 480) ye = 480;
          for (int yy = int'(cmd_y); yy < ye; yy++)
            for (int xx = int'(cmd_x); xx < xe; xx++)
              mq.push_back({10'(xx), 9'(yy), cmd_color});
          if (mq.size() == 0) m_done = 1;
        end
      end
    end
  end

  task automatic clear_logs();
    hs_log.delete(); wr_cyc.delete(); wr_log.delete();
    stl_log.delete(); done_log.delete(); rdy_log.delete();
  endtask

  task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                      input logic [8:0] h, input logic [23:0] col, output int t);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = col;
    t = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin t = cyc; break; end
    end
    if (t < 0) chk("handshake_timeout", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5000; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", cmd_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_wr(input string tag, input int n, input logic [18:0] ea[4],
                        input int ec[4], input logic [23:0] col);
    chk({tag, "_nwr"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      chk({tag, "_addr"}, wr_log[i][42:24], ea[i]);
      chk({tag, "_data"}, wr_log[i][23:0], col);
      chk({tag, "_cyc"}, wr_cyc[i], ec[i]);
    end
  endtask

  task automatic chk_done(input string tag, input int exp_cyc);
    chk({tag, "_ndone"}, done_log.size(), 1);
    if (done_log.size() > 0) chk({tag, "_done_cyc"}, done_log[0], exp_cyc);
  endtask

  initial begin
    int t, t1, t2;
    logic [18:0] ea[4];
    int ec[4];
    int pix0, stl0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; wr_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 19'd0);
    chk("rst_wr_data", wr_data, 24'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Basic 2x2 fill.
    clear_logs();
    send(10'd2, 9'd3, 10'd2, 9'd2, 24'hFF0000, t);
    wait_idle();
    ea = '{{10'd2, 9'd3}, {10'd3, 9'd3}, {10'd2, 9'd4}, {10'd3, 9'd4}};
    ec = '{t + 1, t + 2, t + 3, t + 4};
    chk_wr("fill2x2", 4, ea, ec, 24'hFF0000);
    chk_done("fill2x2", t + 5);
    chk("fill2x2_nrdy", rdy_log.size(), 1);
    if (rdy_log.size() > 0) chk("fill2x2_rdy_cyc", rdy_log[0], t + 6);

    // Clipping at the bottom-right corner.
    clear_logs();
    send(10'd638, 9'd478, 10'd10, 9'd10, 24'h00FF00, t);
    wait_idle();
    ea = '{{10'd638, 9'd478}, {10'd639, 9'd478}, {10'd638, 9'd479}, {10'd639, 9'd479}};
    ec = '{t + 1, t + 2, t + 3, t + 4};
    chk_wr("clip", 4, ea, ec, 24'h00FF00);
    chk_done("clip", t + 5);

    // Empty commands.
    clear_logs();
    send(10'd10, 9'd10, 10'd0, 9'd5, 24'h123456, t);
    wait_idle();
    chk("empty_w_nwr", wr_log.size(), 0);
    chk_done("empty_w", t + 1);
    if (rdy_log.size() > 0) chk("empty_w_rdy_cyc", rdy_log[0], t + 2);
    clear_logs();
    send(10'd700, 9'd10, 10'd5, 9'd5, 24'h654321, t);
    wait_idle();
    chk("empty_x_nwr", wr_log.size(), 0);
    chk_done("empty_x", t + 1);

    // Stall in the middle of a 3-pixel row.
    clear_logs();
`ifdef VMEM_FILL_PERF_EN
    pix0 = pix_count; stl0 = stall_count;
`else
    pix0 = 0; stl0 = 0;
`endif
    send(10'd0, 9'd0, 10'd3, 9'd1, 24'h0000FF, t);
    stall_lo = t + 2; stall_hi = t + 4;
    wait_idle();
    stall_lo = 1 << 30; stall_hi = -1;
    ea = '{{10'd0, 9'd0}, {10'd1, 9'd0}, {10'd2, 9'd0}, 19'd0};
    ec = '{t + 1, t + 5, t + 6, 0};
    chk_wr("stall", 3, ea, ec, 24'h0000FF);
    chk_done("stall", t + 7);
    chk("stall_nhold", stl_log.size(), 3);
    foreach (stl_log[i]) chk("stall_hold_addr", stl_log[i], {10'd1, 9'd0});
`ifdef VMEM_FILL_PERF_EN
    chk("stall_perf_pix", pix_count - pix0, 3);
    chk("stall_perf_stall", stall_count - stl0, 3);
`endif

    // Reset in the middle of a 4x4 fill.
    clear_logs();
    send(10'd20, 9'd20, 10'd4, 9'd4, 24'hABCDEF, t);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_ndone", done_log.size(), 0);
    chk("midrst_nwr", wr_log.size(), 5);
    clear_logs();
    send(10'd30, 9'd30, 10'd1, 9'd1, 24'h5A5A5A, t);
    wait_idle();
    ea = '{{10'd30, 9'd30}, 19'd0, 19'd0, 19'd0};
    ec = '{t + 1, 0, 0, 0};
    chk_wr("after_rst", 1, ea, ec, 24'h5A5A5A);
    chk_done("after_rst", t + 2);

    // Back-to-back with cmd_valid held high.
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_x = 10'd5; cmd_y = 9'd7; cmd_w = 10'd1; cmd_h = 9'd1;
    cmd_color = 24'h111111;
    t1 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin t1 = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_x = 10'd9; cmd_color = 24'h222222;
    t2 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin t2 = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_nhs", hs_log.size(), 2);
    if (hs_log.size() == 2) chk("b2b_gap", hs_log[1] - hs_log[0], 3);
    chk("b2b_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("b2b_addr0", wr_log[0][42:24], {10'd5, 9'd7});
      chk("b2b_data0", wr_log[0][23:0], 24'h111111);
      chk("b2b_addr1", wr_log[1][42:24], {10'd9, 9'd7});
      chk("b2b_data1", wr_log[1][23:0], 24'h222222);
    end

    // Random phase: model checks every cycle.
    stall_rand = 1;
    for (int n = 0; n < 150; n++) begin
      logic [9:0] rx, rw;
      logic [8:0] ry, rh;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      case ($urandom_range(0, 3))
        0: rx = 10'($urandom_range(0, 20));
        1: rx = 10'($urandom_range(600, 639));
        2: rx = 10'($urandom_range(640, 1023));
        default: rx = 10'($urandom_range(0, 639));
      endcase
      case ($urandom_range(0, 3))
        0: ry = 9'($urandom_range(0, 10));
        1: ry = 9'($urandom_range(470, 479));
        2: ry = 9'($urandom_range(480, 511));
        default: ry = 9'($urandom_range(0, 479));
      endcase
      rw = 10'($urandom_range(0, 6));
      rh = 9'($urandom_range(0, 4));
      if (rx >= 10'd600 && $urandom_range(0, 4) == 0) rw = 10'd1023;
      if (ry >= 9'd470 && $urandom_range(0, 4) == 0) rh = 9'd511;
      send(rx, ry, rw, rh, 24'($urandom), t);
      cmd_x = 10'($urandom); cmd_y = 9'($urandom_range(0, 479));
      cmd_w = 10'($urandom_range(0, 3)); cmd_h = 9'($urandom_range(0, 3));
      cmd_color = 24'($urandom);
      cmd_valid = ($urandom_range(0, 3) == 0);
      if (n % 37 == 36) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    stall_rand = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
